// File: rtl/fifo_serial_pkg.sv
// Shared definitions for the FIFO-to-serial reader.
//   state_t     : FSM state encoding (also exported on the debug port)
//   DEF_*       : default word width and baud divisor
//   frame_bits  : number of serial bit periods in one frame
package fifo_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        FETCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    localparam int DEF_DATA_W       = 4;
    localparam int DEF_CLKS_PER_BIT = 16;

    // start bit + data bits + optional parity bit + stop bits
    function automatic int frame_bits(input int data_w, input int parity_en, input int stop_bits);
        return 1 + data_w + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/fifo_serial_reader_tx_baud_gen.sv
// Baud-period counter for the serial transmitter.
//   clk, reset : system clock, synchronous active-low reset
//   clear      : hold the counter at 0 (used while no bit is on the line)
//   bit_end    : high in the last clk cycle of each bit period
//   count      : current position inside the bit period, 0..CLKS_PER_BIT-1
module tx_baud_gen
    import fifo_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    output logic                            bit_end,
    output logic [$clog2(CLKS_PER_BIT)-1:0] count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (count == CNT_W'(CLKS_PER_BIT - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_end = (count == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/fifo_serial_reader.sv
// Pop-side consumer of the push/pop FIFO: pops one word at a time and sends
// it as a UART-style frame (start, data LSB first, optional even parity, stop).
//   clk, reset  : system clock, synchronous active-low reset
//   enable      : allows new frames to start
//   fifo_empty  : FIFO empty flag
//   fifo_data   : FIFO registered read data
//   pop         : one-cycle read strobe to the FIFO
//   tx          : serial line, idles high
//   busy        : high from the pop cycle until the last stop bit ends
//   frame_done  : pulse in the last cycle of the last stop bit
//   frames_sent : completed frame count, wraps at 256
//   state_dbg   : current FSM state
//
// FIFO handshake: pop is a single-cycle strobe raised only when fifo_empty was
// low in the deciding cycle (IDLE or the last STOP cycle). The FIFO presents
// the popped word on fifo_data in the following cycle (FETCH), where it is
// captured. fifo_empty is never looked at again until the frame is finishing,
// so a one-cycle lag on the flag is harmless.
module fifo_serial_reader
    import fifo_serial_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              pop,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frames_sent,
    output logic [2:0]        state_dbg
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t             state, state_n;
    logic [DATA_W-1:0]  shift, shift_n;
    logic               parity, parity_n;
    logic [IDX_W-1:0]   bit_idx, bit_idx_n;
    logic               stop_idx, stop_idx_n;
    logic               tx_n, frame_done_n;
    logic               baud_clear, bit_end;
    logic [CNT_W-1:0]   baud_count;

    // The baud counter only runs while a bit is being driven onto the line.
    assign baud_clear = (state == IDLE) || (state == POP) || (state == FETCH);

    tx_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clear  (baud_clear),
        .bit_end(bit_end),
        .count  (baud_count)
    );

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        parity_n   = parity;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) state_n = POP;
            end
            POP: begin
                state_n = FETCH;
            end
            FETCH: begin
                shift_n    = fifo_data;
                parity_n   = ^fifo_data;
                bit_idx_n  = '0;
                stop_idx_n = 1'b0;
                state_n    = START;
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_n   = shift >> 1;
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == IDX_W'(DATA_W - 1)) begin
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        state_n = (enable && !fifo_empty) ? POP : IDLE;
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are computed from next-cycle values and registered, so tx
        // comes straight from a flop and lines up with the state it belongs to.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = parity_n;
            default: tx_n = 1'b1;
        endcase

        // Next cycle is the last cycle of the last stop bit.
        frame_done_n = (state == STOP) && (stop_idx == 1'(STOP_BITS - 1)) &&
                       (baud_count == CNT_W'(CLKS_PER_BIT - 2));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            shift       <= '0;
            parity      <= 1'b0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            tx          <= 1'b1;
            pop         <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= '0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            parity     <= parity_n;
            bit_idx    <= bit_idx_n;
            stop_idx   <= stop_idx_n;
            tx         <= tx_n;
            pop        <= (state_n == POP);
            busy       <= (state_n != IDLE);
            frame_done <= frame_done_n;
            if (frame_done_n) frames_sent <= frames_sent + 8'd1;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_fifo_serial_reader.sv
`timescale 1ns/1ps
module tb_fifo_serial_reader;
    import fifo_serial_pkg::*;

    localparam int CPB    = 16;
    localparam int FRAME  = frame_bits(4, 1, 1) * CPB;   // 112
    localparam int CPB2   = 4;
    localparam int FRAME2 = frame_bits(4, 0, 2) * CPB2;  // 28

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [3:0] fifo_data = 4'h0;
    logic       pop, tx, busy, frame_done;
    logic [7:0] frames_sent;
    logic [2:0] state_dbg;

    logic       enable2 = 1'b0;
    logic       fifo_empty2 = 1'b1;
    logic [3:0] fifo_data2 = 4'h1;
    logic       pop2, tx2, busy2, frame_done2;
    logic [7:0] frames_sent2;
    logic [2:0] state_dbg2;

    fifo_serial_reader dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .pop(pop), .tx(tx), .busy(busy),
        .frame_done(frame_done), .frames_sent(frames_sent), .state_dbg(state_dbg)
    );

    fifo_serial_reader #(.DATA_W(4), .CLKS_PER_BIT(CPB2), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .fifo_empty(fifo_empty2),
        .fifo_data(fifo_data2), .pop(pop2), .tx(tx2), .busy(busy2),
        .frame_done(frame_done2), .frames_sent(frames_sent2), .state_dbg(state_dbg2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [3:0] fifo_mem[$];
    logic       push_en = 1'b0;
    logic [3:0] push_data = 4'h0;
    logic       rst_hit = 1'b0;

    always @(posedge clk) begin
        rst_hit <= !reset;
        if (pop && fifo_mem.size() > 0) fifo_data <= fifo_mem.pop_front();
        if (push_en) fifo_mem.push_back(push_data);
        fifo_empty <= (fifo_mem.size() == 0);
    end

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [3:0] w);
        push_en   = 1'b1;
        push_data = w;
        exp_q.push_back(w);
        tick();
        push_en = 1'b0;
    endtask

    // ---------------- monitor ----------------
    bit   in_frame = 0;
    bit   pending = 0;
    bit   cnt_chk = 0;
    int   frames_exp = 0;
    int   pop_count = 0;
    int   start_cyc = 0;
    int   last_pop_cyc = -100;
    int   off;
    int   pop_list[$];
    int   start_list[$];
    logic prev_tx = 1'b1;
    logic fbits [0:6];
    logic [3:0] cur_w;

    always @(negedge clk) begin
        if (rst_hit) begin
            check("reset_tx", tx, 1);
            check("reset_busy", busy, 0);
            check("reset_pop", pop, 0);
            check("reset_frame_done", frame_done, 0);
            check("reset_frames_sent", frames_sent, 0);
            in_frame   = 0;
            pending    = 0;
            cnt_chk    = 0;
            frames_exp = 0;
        end else begin
            if (cnt_chk) begin
                check("frames_sent", frames_sent, frames_exp % 256);
                cnt_chk = 0;
            end
            if (pop) begin
                check("pop_while_busy", pending, 0);
                check("pop_fifo_nonempty", fifo_mem.size() > 0, 1);
                pending      = 1;
                last_pop_cyc = cyc;
                pop_count++;
                pop_list.push_back(cyc);
            end
            if (!in_frame && prev_tx && !tx) begin
                in_frame  = 1;
                start_cyc = cyc;
                start_list.push_back(cyc);
                check("start_after_pop", pending, 1);
                check("pop_to_start", cyc - last_pop_cyc, 2);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", exp_q.size(), 1);
                    cur_w = 4'h0;
                end else begin
                    cur_w = exp_q.pop_front();
                end
                // start, data LSB first, even parity, stop
                fbits[0] = 1'b0;
                for (int i = 0; i < 4; i++) fbits[1 + i] = cur_w[i];
                fbits[5] = ^cur_w;
                fbits[6] = 1'b1;
            end
            if (in_frame) begin
                off = cyc - start_cyc;
                check("tx_bit", tx, fbits[off / CPB]);
                check("busy_in_frame", busy, 1);
                check("frame_done", frame_done, off == FRAME - 1);
                if (off == FRAME - 1) begin
                    in_frame = 0;
                    pending  = 0;
                    frames_exp++;
                    cnt_chk  = 1;
                end
            end else begin
                check("tx_idle_high", tx, 1);
                check("frame_done_idle", frame_done, 0);
                check("busy_between", busy, pending);
            end
        end
        prev_tx = tx;
    end

    // ---------------- bounded waits ----------------
    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while (frames_exp < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, frames_exp >= n, 1);
    endtask

    task automatic wait_start(input int n, input int budget, input string tag);
        int k = 0;
        while (start_list.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, start_list.size() >= n, 1);
    endtask

    // ---------------- stimulus ----------------
    int p0, s0, pc0, k2;
    logic bits2 [0:6];
    logic [3:0] w2;

    initial begin
        // reset and idle
        reset  = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (200) tick();
        check("idle_pop_count", pop_count, 0);
        check("idle_frames_sent", frames_sent, 0);
        check("idle_state", state_dbg, IDLE);

        // single word 4'hA
        push_word(4'hA);
        wait_frames(1, 400, "single_timeout");
        tick(); tick();
        check("single_pop_count", pop_count, 1);
        check("single_frames_sent", frames_sent, 1);
        check("single_busy_low", busy, 0);

        // back-to-back 4'h3 then 4'hF
        p0 = pop_list.size();
        s0 = start_list.size();
        push_word(4'h3);
        push_word(4'hF);
        wait_frames(3, 600, "b2b_timeout");
        tick(); tick();
        if (pop_list.size() >= p0 + 2) check("b2b_pop_spacing", pop_list[p0 + 1] - pop_list[p0], 114);
        else check("b2b_pops", pop_list.size(), p0 + 2);
        if (start_list.size() >= s0 + 2) check("b2b_high_gap", start_list[s0 + 1] - start_list[s0] - FRAME, 2);
        else check("b2b_starts", start_list.size(), s0 + 2);
        check("b2b_frames_sent", frames_sent, 3);

        // enable drop in DATA bit 1 with two words still queued
        pc0 = pop_count;
        s0  = start_list.size();
        push_word(4'h5);
        push_word(4'hC);
        push_word(4'h9);
        wait_start(s0 + 1, 100, "drop_start_timeout");
        repeat (2 * CPB + 3) tick();
        enable = 1'b0;
        wait_frames(4, 300, "drop_timeout");
        repeat (300) tick();
        check("drop_pop_count", pop_count - pc0, 1);
        check("drop_queued_left", exp_q.size(), 2);
        check("drop_state_idle", state_dbg, IDLE);
        check("drop_busy_low", busy, 0);

        // drain the two queued words
        enable = 1'b1;
        wait_frames(6, 600, "drain_timeout");
        tick(); tick();
        check("drain_frames_sent", frames_sent, 6);

        // reset during the parity bit
        s0 = start_list.size();
        push_word(4'h7);
        wait_start(s0 + 1, 100, "rst_start_timeout");
        repeat (5 * CPB + 4) tick();
        pc0 = pop_count;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (200) tick();
        check("rst_no_repop", pop_count - pc0, 0);
        check("rst_frames_sent", frames_sent, 0);
        check("rst_tx_high", tx, 1);

        // randomized traffic with random enable gaps
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) != 0) push_word(4'($urandom_range(0, 15)));
            enable = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(1, 150)) tick();
        end
        enable = 1'b1;
        begin
            int k = 0;
            while ((exp_q.size() != 0 || pending || in_frame) && k < 8000) begin
                tick();
                k++;
            end
        end
        repeat (3) tick();
        check("random_drained", exp_q.size(), 0);
        check("random_idle", pending, 0);
        check("random_frames_sent", frames_sent, frames_exp % 256);

        // parameter variant: no parity, two stop bits, 4 clks per bit, word 4'h1
        w2 = 4'h1;
        bits2[0] = 1'b0;
        for (int i = 0; i < 4; i++) bits2[1 + i] = w2[i];
        bits2[5] = 1'b1;
        bits2[6] = 1'b1;
        enable2     = 1'b1;
        fifo_empty2 = 1'b0;
        k2 = 0;
        while (!pop2 && k2 < 50) begin
            tick();
            k2++;
        end
        check("v_pop_seen", pop2, 1);
        fifo_empty2 = 1'b1;
        tick();
        check("v_fetch_tx_high", tx2, 1);
        for (int k = 0; k < FRAME2; k++) begin
            tick();
            check("v_tx_bit", tx2, bits2[k / CPB2]);
            check("v_frame_done", frame_done2, k == FRAME2 - 1);
        end
        tick();
        check("v_after_tx", tx2, 1);
        check("v_after_done", frame_done2, 0);
        check("v_after_busy", busy2, 0);
        check("v_frames_sent", frames_sent2, 1);
        check("v_no_more_pop", pop2, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_serial_reader.md
Name: fifo_serial_reader

Overview:
- Drains 4-bit words from the team's push/pop FIFO as its pop-side consumer.
- Drives `pop`, consumes the FIFO's registered read data and `fifo_empty` flag, and serializes each word onto a UART-style line.
- Frame format is start bit, data bits LSB first, optional even parity, then stop bit(s).
- Sits between the FIFO and an off-chip or debug serial pin; reports progress with a busy flag, a done pulse and a frame counter.

Parameters:
- DATA_W, 4: word width; must match the FIFO data width.
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be >= 2.
- PARITY_EN, 1: 1 = even parity bit after the data bits; 0 = no parity bit.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset; 0 = reset, sampled on the rising edge of clk.
- enable  input  1  1 = allowed to start new frames.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_W  FIFO registered read data (the FIFO's data_out).
- pop  output  1  one-cycle read strobe to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  1 from the POP state until the last stop bit ends.
- frame_done  output  1  one-cycle pulse in the last cycle of the last stop bit.
- frames_sent  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; tx=1, pop=0, busy=0, frame_done=0, frames_sent=0.
  - Baud counter, bit index and shift register all cleared.
- Reset mid-frame: tx=1 from the next cycle; the partially sent word is discarded and is not re-popped.
- All outputs are registered; tx is glitch-free.
- States: IDLE, POP, FETCH, START, DATA, PARITY, STOP.
- IDLE: if enable=1 and fifo_empty=0 -> POP; otherwise remain in IDLE with tx=1.
- POP:
  - pop=1 for exactly this one cycle; tx=1.
  - Always -> FETCH. The FIFO updates data_out at the end of this cycle.
- FETCH:
  - tx=1; fifo_data is captured into the shift register at the end of this cycle.
  - Parity is computed as the XOR of the captured bits. -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles; then shift right and increment the bit index.
  - After DATA_W bits -> PARITY if PARITY_EN=1, else -> STOP.
- PARITY: tx = even parity bit (number of ones in data+parity is even) for CLKS_PER_BIT cycles -> STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - In its final cycle: frame_done=1 and frames_sent increments.
  - Next state: POP if enable=1 and fifo_empty=0, else IDLE.
- Latency:
  - The pop cycle is t; tx falls at t+2.
  - Frame length = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles; defaults give 112 cycles.
  - Back-to-back frames have a 2-cycle high gap (POP, FETCH) between the last stop bit and the next start bit.
- The baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary; it is held at 0 in IDLE, POP and FETCH.
- Empty handling:
  - pop is never asserted while fifo_empty=1.
  - fifo_empty is sampled only in IDLE and in the last STOP cycle, which is at least CLKS_PER_BIT cycles after the previous pop. This tolerates the FIFO's one-cycle flag lag.
- Enable:
  - Deasserting enable mid-frame does not abort the frame; it completes, then the block returns to IDLE.
  - enable is ignored in POP and FETCH: a started pop is always transmitted.
- frames_sent wraps modulo 256 with no saturation.

Decomposition:
- Shared package fifo_serial_pkg:
  - State enum (3-bit encoding: IDLE=0, POP=1, FETCH=2, START=3, DATA=4, PARITY=5, STOP=6).
  - Default constants DATA_W, CLKS_PER_BIT.
  - FRAME_BITS function = 1 + DATA_W + PARITY_EN + STOP_BITS.
- Sub-module tx_baud_gen: counter with a clear input that outputs a bit_end tick at count CLKS_PER_BIT-1. The FSM, shift register and parity stay in the top module.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles, fifo_empty=1, enable=1 -> tx=1, pop=0, busy=0, frames_sent=0; pop stays 0 for 200 cycles.
- Single word: FIFO model with one entry 4'hA, enable=1 -> one pop pulse.
  - tx falls 2 cycles after the pop pulse.
  - Bit sequence is 0,0,1,0,1,0(parity),1, each 16 cycles.
  - frame_done pulses once; frames_sent=1.
- Back-to-back: FIFO holds 4'h3 then 4'hF.
  - Two pops, 114 cycles apart.
  - Second frame bits are 0,1,1,1,1,0(parity),1.
  - Exactly a 2-cycle high gap between the two frames; frames_sent=2.
- Enable drop: deassert enable during the DATA bit 1 of a frame, with 2 words still queued -> current frame completes intact, no further pop, and the block returns to IDLE.
- Reset mid-frame: assert reset=0 during the PARITY bit -> next cycle tx=1, busy=0, frames_sent=0, no frame_done pulse.
- Parameter variant PARITY_EN=0, STOP_BITS=2, CLKS_PER_BIT=4, word 4'h1:
  - Bit sequence is 0,1,0,0,0,1,1.
  - Frame is 28 cycles; frame_done falls in the last stop cycle.
